int_svc_ctrl: RTL and testbench
===============================

Name: int_svc_ctrl

Overview:
- Consumer side of the interrupt system's request register.
- Watches the device request lines, latches rising edges into a pending register and masks them.
- Picks the highest-priority request, raises int_out to the CPU, and runs an int_out/inta/iret handshake.
- On acknowledge it returns a vector and clears the serviced pending bit. No nesting: one interrupt is in service at a time.

Parameters:
- N, 4, number of interrupt request lines (2..16); index 0 is highest priority.
- VW, 8, vector width in bits.
- VBASE, 8'h20, base vector; vector = VBASE + winning index (modulo 2^VW).

Ports:
- clk  input  1  clock; all state updates on posedge.
- clr  input  1  asynchronous, active-low reset.
- irq_in  input  N  device request lines; a rising edge is a request.
- mask  input  N  per-line mask; 1 blocks that line from being selected.
- ien  input  1  global interrupt enable.
- inta  input  1  CPU interrupt acknowledge, 1-cycle pulse.
- iret  input  1  CPU return-from-interrupt, 1-cycle pulse.
- int_out  output  1  interrupt request to CPU (registered).
- vector  output  VW  vector of the serviced interrupt (registered).
- active  output  1  an interrupt is in service (registered).
- pend  output  N  pending request register, status (registered).

Behaviour:
- Reset (clr=0, asynchronous): state=IDLE; int_out=0, vector=0, active=0, pend=0; edge-detect register irq_q=0; winner index=0.
  - A line held high when clr releases counts as a new edge on the first clock.
- Edge capture, every cycle: pend[i] is set when irq_in[i]=1 and irq_q[i]=0; then irq_q <= irq_in.
- Set/clear collision: if a new edge on line i coincides with the inta clear of line i, set wins and pend[i] stays 1.
- Eligible requests: elig = pend & ~mask. Winner = lowest index with elig=1 (fixed priority).
- State IDLE:
  - If ien=1 and elig!=0: latch winner index, int_out<=1, go to REQ.
  - Otherwise stay. inta and iret are ignored.
- State REQ:
  - The latched winner is committed. Later changes to mask, ien or pend do not withdraw or re-arbitrate it.
  - int_out stays 1 until inta=1 is sampled. Then: int_out<=0, vector<=VBASE+idx, active<=1, pend[idx]<=0, go to SERV.
  - iret is ignored.
- State SERV:
  - int_out=0; vector and active hold.
  - On iret=1: active<=0, vector<=0, go to IDLE.
  - inta is ignored. New edges keep accumulating in pend.
- inta and iret asserted in the same cycle: each is honoured only in its own state (inta in REQ, iret in SERV).
- Latency:
  - irq edge first sampled at edge t: pend bit visible after t; int_out=1 after t+1 (2 cycles).
  - inta sampled at edge u: vector, active, and pend clear visible after u.
  - iret sampled at edge w: IDLE after w; the next pending request raises int_out after w+1.
- Reset mid-operation (any state): returns immediately to the reset values above. Pending requests are discarded.
- Level-high lines produce exactly one request per rising edge, never a repeat while held.

Test Plan:
- Single request: reset, N=4, mask=0, ien=1; irq_in[2] 0->1 at edge t -> pend=4'b0100 after t, int_out=1 after t+1; pulse inta -> vector=8'h22, active=1, pend=0, int_out=0; pulse iret -> active=0, vector=0, int_out stays 0.
- Priority and masking: edges on lines 1 and 3 in the same cycle with mask=4'b0010 -> winner 3, vector=8'h23; after iret, set mask=0 -> line 1 is serviced next, vector=8'h21.
- Commit in REQ: line 0 wins and int_out=1; then set mask[0]=1 and ien=0 before inta -> int_out stays 1, inta still yields vector=8'h20.
- Collision: line 2 rises again in the same cycle inta clears line 2 -> pend[2]=1 after the edge; it is re-serviced after iret.
- Ignored strobes and no nesting: iret in IDLE and inta in SERV cause no state or output change; an edge on line 0 during SERV only sets pend[0], and int_out stays 0 until after iret.
- Async reset: assert clr=0 mid-cycle while in SERV -> int_out, active, vector and pend go to 0 without a clock edge; irq_in[1] held high at release -> pend[1]=1 after the first edge.

Source files
------------

// File: rtl/int_svc_ctrl.sv
// Interrupt service controller: latches request edges into a pending register,
// arbitrates by fixed priority, and runs the int_out/inta/iret CPU handshake.
module int_svc_ctrl #(
   parameter int          N     = 4,
   parameter int          VW    = 8,
   parameter logic [VW-1:0] VBASE = 8'h20
) (
   input  logic          clk,
   input  logic          clr,
   input  logic [N-1:0]  irq_in,
   input  logic [N-1:0]  mask,
   input  logic          ien,
   input  logic          inta,
   input  logic          iret,
   output logic          int_out,
   output logic [VW-1:0] vector,
   output logic          active,
   output logic [N-1:0]  pend
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_SERV = 2'd2;

   // Handshake: int_out is held high from arbitration until the CPU samples it
   // with a one-cycle inta; the vector is then valid with active=1 until iret.
   logic [1:0]    state;
   logic [N-1:0]  irq_q;
   logic [IW-1:0] idx;

   logic [N-1:0]  edge_set;
   logic [N-1:0]  elig;
   logic [N-1:0]  clr_vec;
   logic [IW-1:0] win;
   logic          take_ack;

   assign edge_set = irq_in & ~irq_q;
   assign elig     = pend & ~mask;
   assign take_ack = (state == S_REQ) && inta;

   // Descending scan so the lowest eligible index is the last assignment.
   always_comb begin
      win = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (elig[i]) win = IW'(i);
      end
   end

   always_comb begin
      clr_vec = '0;
      if (take_ack) clr_vec[idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         irq_q <= '0;
         pend  <= '0;
      end else begin
         irq_q <= irq_in;
         // A fresh edge on the line being acknowledged survives the clear.
         pend  <= (pend & ~clr_vec) | edge_set;
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state   <= S_IDLE;
         idx     <= '0;
         int_out <= 1'b0;
         vector  <= '0;
         active  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (ien && (elig != '0)) begin
                  idx     <= win;
                  int_out <= 1'b1;
                  state   <= S_REQ;
               end
            end
            S_REQ: begin
               if (inta) begin
                  int_out <= 1'b0;
                  vector  <= VBASE + VW'(idx);
                  active  <= 1'b1;
                  state   <= S_SERV;
               end
            end
            S_SERV: begin
               if (iret) begin
                  active <= 1'b0;
                  vector <= '0;
                  state  <= S_IDLE;
               end
            end
            default: begin
               state   <= S_IDLE;
               int_out <= 1'b0;
               active  <= 1'b0;
               vector  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_int_svc_ctrl.sv
// Directed bench for int_svc_ctrl: inputs change and outputs are checked 1ns
// after each rising edge, against hand-computed values.
module tb_int_svc_ctrl;

   logic       clk;
   logic       clr;
   logic [3:0] irq_in;
   logic [3:0] mask;
   logic       ien;
   logic       inta;
   logic       iret;
   logic       int_out;
   logic [7:0] vector;
   logic       active;
   logic [3:0] pend;

   int checks = 0;
   int errors = 0;

   int_svc_ctrl #(.N(4), .VW(8), .VBASE(8'h20)) dut (
      .clk(clk), .clr(clr), .irq_in(irq_in), .mask(mask), .ien(ien),
      .inta(inta), .iret(iret), .int_out(int_out), .vector(vector),
      .active(active), .pend(pend)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_inta();
      inta = 1'b1;
      tick();
      inta = 1'b0;
   endtask

   task automatic pulse_iret();
      iret = 1'b1;
      tick();
      iret = 1'b0;
   endtask

   task automatic test_reset();
      clr = 1'b0; irq_in = '0; mask = '0; ien = 1'b1; inta = 1'b0; iret = 1'b0;
      #3;
      checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL reset_int_out: got %b exp 0", int_out); end
      checks++; if (vector !== 8'h00) begin errors++; $display("FAIL reset_vector: got %h exp 00", vector); end
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b exp 0", active); end
      checks++; if (pend !== 4'b0000) begin errors++; $display("FAIL reset_pend: got %b exp 0000", pend); end
      tick();
      tick();
      clr = 1'b1;
      tick();
      checks++; if (int_out !== 1'b0 || pend !== 4'b0000) begin errors++; $display("FAIL reset_idle: got int_out=%b pend=%b exp 0 0000", int_out, pend); end
   endtask

   task automatic test_single();
      irq_in = 4'b0100;
      tick();
      checks++; if (pend !== 4'b0100) begin errors++; $display("FAIL single_pend: got %b exp 0100", pend); end
      checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL single_int_early: got %b exp 0", int_out); end
      tick();
      checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL single_int_out: got %b exp 1", int_out); end
      pulse_inta();
      checks++; if (vector !== 8'h22) begin errors++; $display("FAIL single_vector: got %h exp 22", vector); end
      checks++; if (active !== 1'b1) begin errors++; $display("FAIL single_active: got %b exp 1", active); end
      checks++; if (pend !== 4'b0000) begin errors++; $display("FAIL single_pend_clr: got %b exp 0000", pend); end
      checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL single_int_drop: got %b exp 0", int_out); end
      pulse_iret();
      checks++; if (active !== 1'b0 || vector !== 8'h00) begin errors++; $display("FAIL single_iret: got active=%b vector=%h exp 0 00", active, vector); end
      tick();
      checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL single_quiet: got %b exp 0", int_out); end
      irq_in = 4'b0000;
      tick();
   endtask

   task automatic test_priority();
      mask = 4'b0010;
      irq_in = 4'b1010;
      tick();
      checks++; if (pend !== 4'b1010) begin errors++; $display("FAIL prio_pend: got %b exp 1010", pend); end
      tick();
      checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL prio_int_out: got %b exp 1", int_out); end
      pulse_inta();
      checks++; if (vector !== 8'h23) begin errors++; $display("FAIL prio_masked_vector: got %h exp 23", vector); end
      checks++; if (pend !== 4'b0010) begin errors++; $display("FAIL prio_pend_left: got %b exp 0010", pend); end
      pulse_iret();
      checks++; if (int_out !== 1'b0 || active !== 1'b0) begin errors++; $display("FAIL prio_masked_idle: got int_out=%b active=%b exp 0 0", int_out, active); end
      mask = 4'b0000;
      tick();
      checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL prio_unmask_int: got %b exp 1", int_out); end
      pulse_inta();
      checks++; if (vector !== 8'h21) begin errors++; $display("FAIL prio_unmask_vector: got %h exp 21", vector); end
      pulse_iret();
      irq_in = 4'b0000;
      tick();
   endtask

   task automatic test_commit();
      irq_in = 4'b0001;
      tick();
      tick();
      checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL commit_int_out: got %b exp 1", int_out); end
      mask = 4'b0001;
      ien = 1'b0;
      tick();
      tick();
      checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL commit_hold: got %b exp 1", int_out); end
      pulse_inta();
      checks++; if (vector !== 8'h20 || active !== 1'b1) begin errors++; $display("FAIL commit_vector: got vector=%h active=%b exp 20 1", vector, active); end
      mask = 4'b0000;
      ien = 1'b1;
      pulse_iret();
      irq_in = 4'b0000;
      tick();
   endtask

   task automatic test_collision();
      irq_in = 4'b0100;
      tick();
      tick();
      checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL coll_int_out: got %b exp 1", int_out); end
      irq_in = 4'b0000;
      tick();
      irq_in = 4'b0100;
      pulse_inta();
      checks++; if (pend !== 4'b0100) begin errors++; $display("FAIL coll_set_wins: got %b exp 0100", pend); end
      checks++; if (vector !== 8'h22) begin errors++; $display("FAIL coll_vector: got %h exp 22", vector); end
      pulse_iret();
      checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL coll_iret_idle: got %b exp 0", int_out); end
      tick();
      checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL coll_reservice: got %b exp 1", int_out); end
      pulse_inta();
      checks++; if (vector !== 8'h22 || pend !== 4'b0000) begin errors++; $display("FAIL coll_second: got vector=%h pend=%b exp 22 0000", vector, pend); end
      pulse_iret();
      irq_in = 4'b0000;
      tick();
   endtask

   task automatic test_ignored();
      pulse_iret();
      checks++; if (int_out !== 1'b0 || active !== 1'b0 || vector !== 8'h00) begin errors++; $display("FAIL ign_iret_idle: got int_out=%b active=%b vector=%h exp 0 0 00", int_out, active, vector); end
      irq_in = 4'b1000;
      tick();
      tick();
      pulse_inta();
      checks++; if (vector !== 8'h23 || active !== 1'b1) begin errors++; $display("FAIL ign_enter_serv: got vector=%h active=%b exp 23 1", vector, active); end
      pulse_inta();
      checks++; if (vector !== 8'h23 || active !== 1'b1 || int_out !== 1'b0 || pend !== 4'b0000) begin errors++; $display("FAIL ign_inta_serv: got vector=%h active=%b int_out=%b pend=%b exp 23 1 0 0000", vector, active, int_out, pend); end
      irq_in = 4'b1001;
      tick();
      checks++; if (pend !== 4'b0001 || int_out !== 1'b0) begin errors++; $display("FAIL ign_nest_pend: got pend=%b int_out=%b exp 0001 0", pend, int_out); end
      tick();
      checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL ign_no_nest: got %b exp 0", int_out); end
      pulse_iret();
      checks++; if (int_out !== 1'b0 || active !== 1'b0) begin errors++; $display("FAIL ign_after_iret: got int_out=%b active=%b exp 0 0", int_out, active); end
      tick();
      checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL ign_next_req: got %b exp 1", int_out); end
      pulse_inta();
      checks++; if (vector !== 8'h20) begin errors++; $display("FAIL ign_next_vector: got %h exp 20", vector); end
   endtask

   task automatic test_async_reset();
      irq_in = 4'b0000;
      tick();
      irq_in = 4'b0100;
      tick();
      checks++; if (pend !== 4'b0100 || active !== 1'b1) begin errors++; $display("FAIL areset_pre: got pend=%b active=%b exp 0100 1", pend, active); end
      #2;
      clr = 1'b0;
      #1;
      checks++; if (int_out !== 1'b0 || active !== 1'b0 || vector !== 8'h00 || pend !== 4'b0000) begin errors++; $display("FAIL areset_async: got int_out=%b active=%b vector=%h pend=%b exp 0 0 00 0000", int_out, active, vector, pend); end
      irq_in = 4'b0010;
      #1;
      clr = 1'b1;
      tick();
      checks++; if (pend !== 4'b0010) begin errors++; $display("FAIL areset_held_line: got %b exp 0010", pend); end
      tick();
      checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL areset_int_out: got %b exp 1", int_out); end
      pulse_inta();
      checks++; if (vector !== 8'h21) begin errors++; $display("FAIL areset_vector: got %h exp 21", vector); end
      pulse_iret();
      tick();
      checks++; if (pend !== 4'b0000 || int_out !== 1'b0) begin errors++; $display("FAIL areset_no_repeat: got pend=%b int_out=%b exp 0000 0", pend, int_out); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_priority();
      test_commit();
      test_collision();
      test_ignored();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
